// File: rtl/mem_io_responder.sv
// mem_io_responder: byte-serial memory responder with on-chip RAM, a TX FIFO at 0x30000 and a sticky halt at 0x30004.
// Reads are read-first with one cycle of latency; the FIFO drains over a valid/ready port.
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_WIDTH = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        overflow,
    output logic        halt
);
    localparam logic [17:0] TX_ADDR = 18'h30000;
    localparam logic [17:0] HALT_ADDR = 18'h30004;
    localparam logic [FIFO_WIDTH:0] DEPTH_C = (FIFO_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [FIFO_WIDTH:0] NEAR_FULL_C = (FIFO_WIDTH+1)'(FIFO_DEPTH - 2);

    logic [7:0]            ram [2**ADDR_WIDTH];
    logic [7:0]            fifo_q [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [FIFO_WIDTH:0]   count_q, count_d;
    logic [7:0]            mem_din_q, mem_din_d;
    logic                  ibf_q, ibf_d, ovf_q, ovf_d, halt_q, halt_d;
    logic                  is_io, wr_en, push_req, push, pop, full;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  unused_bits;

    assign unused_bits = ^mem_a[31:18];

    always_comb begin
        is_io    = mem_a[17:16] == 2'b11;
        idx      = mem_a[ADDR_WIDTH-1:0];
        wr_en    = rdy_in && mem_wr;
        push_req = wr_en && (mem_a[17:0] == TX_ADDR);
        pop      = tx_valid && tx_ready;
        full     = count_q == DEPTH_C;
        // a same-cycle pop frees the slot, so a push into a full FIFO still lands
        push     = push_req && (!full || pop);
        head_d   = pop ? head_q + 1'b1 : head_q;
        tail_d   = push ? tail_q + 1'b1 : tail_q;
        count_d  = count_q + (FIFO_WIDTH+1)'(push) - (FIFO_WIDTH+1)'(pop);
        ibf_d    = count_d >= NEAR_FULL_C;
        ovf_d    = ovf_q || (push_req && !push);
        halt_d   = halt_q || (wr_en && (mem_a[17:0] == HALT_ADDR));
        mem_din_d = rdy_in ? (is_io ? 8'h00 : ram[idx]) : mem_din_q;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            mem_din_q <= '0;
            ibf_q     <= 1'b0;
            ovf_q     <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            mem_din_q <= mem_din_d;
            ibf_q     <= ibf_d;
            ovf_q     <= ovf_d;
            halt_q    <= halt_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_en && !is_io) ram[idx] <= mem_dout;
    end

    always_ff @(posedge clk_in) begin
        if (push) fifo_q[tail_q] <= mem_dout;
    end

    assign mem_din        = mem_din_q;
    assign io_buffer_full = ibf_q;
    assign overflow       = ovf_q;
    assign halt           = halt_q;
    assign tx_valid       = count_q != '0;
    assign tx_data        = fifo_q[head_q];
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed plus randomized traffic scored against a queue-based model of RAM, FIFO and sticky flags.
module tb_mem_io_responder;
    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic [31:0] mem_a = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        overflow;
    logic        halt;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .overflow(overflow), .halt(halt)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit         din_chk;
        logic [7:0] din;
        bit         v, ibf, ovf, hlt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] mram[int];
    logic [7:0] mq[$];
    bit         movf, mhalt, mdin_known;
    logic [7:0] mdin;
    int         tests = 0;
    int         fails = 0;
    logic [16:0] pool[16];

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endfunction

    // One bus cycle: drive inputs, advance the model, queue the post-edge expectation.
    task automatic cyc(input bit rdy, input bit wr, input logic [31:0] a, input logic [7:0] d,
                       input bit ready, input bit rstn = 1'b1);
        exp_t e;
        int   idx;
        bit   io, pop;
        rdy_in = rdy; mem_wr = wr; mem_a = a; mem_dout = d; tx_ready = ready; rst_n_in = rstn;
        idx = int'(a[16:0]);
        io = a[17:16] == 2'b11;
        if (!rstn) begin
            mq.delete(); tx_q.delete();
            movf = 0; mhalt = 0; mdin = 8'h00; mdin_known = 1;
        end else begin
            pop = ready && mq.size() > 0;
            if (rdy) begin
                if (io) begin mdin = 8'h00; mdin_known = !wr; end
                else if (mram.exists(idx)) begin mdin = mram[idx]; mdin_known = 1; end
                else mdin_known = 0;
                if (wr && !io) mram[idx] = d;
                if (wr && a[17:0] == 18'h30004) mhalt = 1;
            end
            if (pop) void'(mq.pop_front());
            if (rdy && wr && a[17:0] == 18'h30000) begin
                if (mq.size() < 8) begin mq.push_back(d); tx_q.push_back(d); end
                else movf = 1;
            end
        end
        e.din_chk = mdin_known; e.din = mdin;
        e.v = mq.size() != 0; e.ibf = mq.size() >= 6; e.ovf = movf; e.hlt = mhalt;
        exp_q.push_back(e);
        @(posedge clk_in); #2;
    endtask

    always begin
        exp_t e;
        @(posedge clk_in); #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.din_chk) chk("mem_din", mem_din, e.din);
            chk("tx_valid", tx_valid, e.v);
            chk("io_buffer_full", io_buffer_full, e.ibf);
            chk("overflow", overflow, e.ovf);
            chk("halt", halt, e.hlt);
        end
    end

    always @(negedge clk_in) begin
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL tx_unexpected: got %0h expected no handshake at %0t", tx_data, $time);
            end else chk("tx_data", tx_data, tx_q.pop_front());
        end
    end

    initial begin
        logic [16:0] ix;
        logic [31:0] a;
        bit rdy, rdyx;
        int op;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // RAM latency
        cyc(1, 1, 32'h10, 8'hA5, 0);
        cyc(1, 1, 32'h11, 8'h3C, 0);
        cyc(1, 0, 32'h10, 0, 0);
        cyc(1, 0, 32'hFFFC0011, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // read-first collision
        cyc(1, 1, 32'h20, 8'h11, 0);
        cyc(1, 1, 32'h20, 8'h22, 0);
        cyc(1, 0, 32'h20, 0, 0);
        // FIFO fill, overflow, drain
        for (int i = 0; i < 9; i++) cyc(1, 1, {8'(i), 24'h030000}, 8'(8'h41 + i), 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0);
        // push and pop at full
        for (int i = 0; i < 8; i++) cyc(1, 1, 32'h30000, 8'(8'h60 + i), 0);
        cyc(1, 1, 32'h30000, 8'h50, 1);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 1);
        // rdy_in gating and sticky halt
        cyc(1, 1, 32'h30, 8'h77, 0);
        cyc(0, 1, 32'h30004, 8'h01, 0);
        cyc(0, 1, 32'h30, 8'h99, 0);
        cyc(1, 0, 32'h30, 0, 0);
        cyc(1, 1, 32'h30004, 8'h01, 0);
        cyc(1, 1, 32'h31, 8'h12, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 32'h31, 0, 0);
        cyc(1, 0, 32'h30000, 0, 0);
        // reset mid-operation
        cyc(1, 1, 32'h40, 8'h5A, 0);
        for (int i = 0; i < 3; i++) cyc(1, 1, 32'h30000, 8'(8'h70 + i), 0);
        cyc(1, 1, 32'h30004, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 32'h40, 0, 0);
        // randomized traffic
        for (int i = 0; i < 16; i++) pool[i] = 17'($urandom);
        pool[0] = 17'h00000; pool[1] = 17'h1FFFF; pool[2] = 17'h0FFFF;
        for (int i = 0; i < 800; i++) begin
            ix = pool[$urandom_range(15)];
            a = {14'($urandom), (ix[16] ? 1'b0 : 1'($urandom)), ix};
            rdy = $urandom_range(9) != 0;
            rdyx = $urandom_range(9) < 3;
            op = $urandom_range(39);
            if ($urandom_range(149) == 0) cyc(0, 0, 0, 0, 0, 0);
            else if (op < 10) cyc(rdy, 1, a, 8'($urandom), rdyx);
            else if (op < 18) cyc(rdy, !mram.exists(int'(ix)), a, 8'($urandom), rdyx);
            else if (op < 32) cyc(rdy, 1, {14'($urandom), 18'h30000}, 8'($urandom), rdyx);
            else if (op < 35) cyc(rdy, 1, {14'($urandom), 18'h30001 + 18'($urandom_range(2))}, 8'($urandom), rdyx);
            else if (op < 36) cyc(rdy, 1, 32'h30004, 8'($urandom), rdyx);
            else cyc(rdy, 0, {14'($urandom), 2'b11, 16'($urandom)}, 0, rdyx);
        end
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0, 1);
        chk("tx_q_empty", tx_q.size(), 0);
        @(posedge clk_in); #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
